// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the EX-stage divide sequencer: ALU control codes and FSM states.
package div_sequencer_pkg;

  localparam int unsigned AluCtrlW = 8;

  localparam logic [AluCtrlW-1:0] EXE_DIV_OP  = 8'h1a;
  localparam logic [AluCtrlW-1:0] EXE_DIVU_OP = 8'h1b;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_core.sv
// Restoring radix-2 divide datapath: one shift-subtract step per step_i on unsigned operands.
module div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_next_o,
  output logic [WIDTH-1:0] quo_next_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // The partial remainder stays below the divisor, so bit WIDTH of diff is a clean borrow flag.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    if (diff[WIDTH]) begin
      rem_next_o = trial[WIDTH-1:0];
      quo_next_o = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_next_o = diff[WIDTH-1:0];
      quo_next_o = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
    end else if (step_i) begin
      rem_d = rem_next_o;
      quo_d = quo_next_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// EX-stage divide controller: captures operands, stalls the pipe while dividing and
// presents the sign-corrected remainder (hi) / quotient (lo) pair for the HI/LO write.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] alucontrolE,
  input  logic [WIDTH-1:0]  srcaE,
  input  logic [WIDTH-1:0]  srcbE,
  input  logic              annul,
  input  logic              hold,
  output logic              stall_div,
  output logic              result_valid,
  output logic [WIDTH-1:0]  hi_o,
  output logic [WIDTH-1:0]  lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_div, is_signed, start;
  logic             core_load, core_step;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] rem_next, quo_next;

  assign is_signed = (alucontrolE == CTRL_W'(EXE_DIV_OP));
  assign is_div    = is_signed | (alucontrolE == CTRL_W'(EXE_DIVU_OP));
  assign start     = (state_q == StIdle) & is_div & ~annul;

  // |0x80000000| wraps to itself, which the unsigned core handles correctly.
  assign abs_a = (is_signed & srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign abs_b = (is_signed & srcbE[WIDTH-1]) ? -srcbE : srcbE;

  div_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (core_load),
    .step_i     (core_step),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .rem_next_o (rem_next),
    .quo_next_o (quo_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          neg_quo_d = is_signed & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
          neg_rem_d = is_signed & srcaE[WIDTH-1];
          cnt_d     = '0;
          if (srcbE == '0) begin
            state_d = StDone;
            lo_d    = '1;
            hi_d    = srcaE;
          end else begin
            state_d   = StBusy;
            core_load = 1'b1;
          end
        end
      end
      StBusy: begin
        if (annul) begin
          state_d = StIdle;
        end else begin
          core_step = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LastStep) begin
            state_d = StDone;
            hi_d    = neg_rem_q ? -rem_next : rem_next;
            lo_d    = neg_quo_q ? -quo_next : quo_next;
          end
        end
      end
      StDone: begin
        if (annul || !hold) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // An annulled instruction must never write HI/LO, even in its DONE cycle.
  assign stall_div    = start | (state_q == StBusy);
  assign result_valid = (state_q == StDone) & ~annul;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: scenario tasks with a queue of expected results.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  localparam logic [7:0] NopOp = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  alucontrolE = NopOp;
  logic [31:0] srcaE = '0;
  logic [31:0] srcbE = '0;
  logic        annul = 1'b0;
  logic        hold = 1'b0;
  logic        stall_div, result_valid;
  logic [31:0] hi_o, lo_o;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } res_t;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  div_sequencer #(
    .WIDTH  (32),
    .CTRL_W (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alucontrolE  (alucontrolE),
    .srcaE        (srcaE),
    .srcbE        (srcbE),
    .annul        (annul),
    .hold         (hold),
    .stall_div    (stall_div),
    .result_valid (result_valid),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [7:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    res_t m;
    logic [31:0] ua, ub, q, r;
    logic s;
    s = (op == EXE_DIV_OP);
    if (b == 32'd0) begin
      m.lo = 32'hFFFF_FFFF;
      m.hi = a;
      return m;
    end
    ua = (s && a[31]) ? (32'd0 - a) : a;
    ub = (s && b[31]) ? (32'd0 - b) : b;
    q = ua / ub;
    r = ua % ub;
    m.lo = (s && (a[31] != b[31])) ? (32'd0 - q) : q;
    m.hi = (s && a[31]) ? (32'd0 - r) : r;
    return m;
  endfunction

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    @(negedge clk);
    alucontrolE = op;
    srcaE = a;
    srcbE = b;
    if (push) exp_q.push_back(model(op, a, b));
  endtask

  // Counts stalled cycles until result_valid; EX moves on to a NOP during the DONE cycle.
  task automatic wait_done(output int stalls, output res_t got, output bit ok);
    int n;
    stalls = 0;
    ok = 1'b0;
    n = 0;
    got = '0;
    while (!ok && n < 100) begin
      #1;
      if (result_valid) begin
        got.lo = lo_o;
        got.hi = hi_o;
        ok = 1'b1;
        alucontrolE = NopOp;
        srcaE = $urandom;
        srcbE = $urandom;
      end else begin
        if (stall_div) stalls++;
        n++;
        @(negedge clk);
      end
    end
  endtask

  task automatic check_result(input string name, input int exp_stalls);
    int stalls;
    res_t got, exp;
    bit ok;
    wait_done(stalls, got, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: result_valid never seen", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    exp = exp_q.pop_front();
    checks++;
    if (stalls !== exp_stalls) begin
      errors++;
      $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, exp_stalls);
    end
    checks++;
    if (got.lo !== exp.lo) begin
      errors++;
      $display("FAIL %s lo: got %h want %h", name, got.lo, exp.lo);
    end
    checks++;
    if (got.hi !== exp.hi) begin
      errors++;
      $display("FAIL %s hi: got %h want %h", name, got.hi, exp.hi);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({stall_div, result_valid, hi_o, lo_o} !== 66'd0) begin
      errors++;
      $display("FAIL reset: got stall=%b valid=%b hi=%h lo=%h want all 0", stall_div,
               result_valid, hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_divu_basic();
    exp_q.push_back('{lo: 32'd14, hi: 32'd2});
    issue(EXE_DIVU_OP, 32'd100, 32'd7, 1'b0);
    check_result("divu_100_7", 33);
    @(negedge clk);
    #1;
    checks++;
    if (result_valid !== 1'b0 || stall_div !== 1'b0) begin
      errors++;
      $display("FAIL divu one-cycle valid: got valid=%b stall=%b want 0 0", result_valid,
               stall_div);
    end
  endtask

  task automatic test_signed();
    exp_q.push_back('{lo: 32'hFFFF_FFFD, hi: 32'hFFFF_FFFF});
    issue(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_result("div_m7_2", 33);
    exp_q.push_back('{lo: 32'hFFFF_FFFD, hi: 32'd1});
    issue(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 1'b0);
    check_result("div_7_m2", 33);
    exp_q.push_back('{lo: 32'h8000_0000, hi: 32'd0});
    issue(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_result("div_overflow", 33);
  endtask

  task automatic test_div_zero();
    exp_q.push_back('{lo: 32'hFFFF_FFFF, hi: 32'h1234_5678});
    issue(EXE_DIVU_OP, 32'h1234_5678, 32'd0, 1'b0);
    check_result("divu_by_zero", 1);
  endtask

  task automatic test_random();
    logic [7:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      op = (i % 2 == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
      a = $urandom;
      b = (i == 4) ? 32'd1 : ($urandom >> (i * 4));
      issue(op, a, b, 1'b1);
      check_result("random", (b == 32'd0) ? 1 : 33);
    end
  endtask

  task automatic test_annul();
    bit seen;
    issue(EXE_DIVU_OP, 32'hFFFF_0000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    annul = 1'b1;
    alucontrolE = NopOp;
    @(negedge clk);
    annul = 1'b0;
    #1;
    checks++;
    if (stall_div !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL annul busy: got stall=%b valid=%b want 0 0", stall_div, result_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (result_valid || stall_div) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL annul no result: got activity=%b want 0", seen);
    end
    exp_q.push_back('{lo: 32'd3, hi: 32'd0});
    issue(EXE_DIVU_OP, 32'd9, 32'd3, 1'b0);
    check_result("divu_9_3_after_annul", 33);
  endtask

  task automatic test_hold();
    res_t exp;
    exp = model(EXE_DIVU_OP, 32'hDEAD_BEEF, 32'h1234);
    issue(EXE_DIVU_OP, 32'hDEAD_BEEF, 32'h1234, 1'b1);
    check_result("hold_first", 33);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (result_valid !== 1'b1 || stall_div !== 1'b0 || lo_o !== exp.lo || hi_o !== exp.hi)
      begin
        errors++;
        $display("FAIL hold cycle %0d: got valid=%b stall=%b lo=%h hi=%h want 1 0 %h %h", i,
                 result_valid, stall_div, lo_o, hi_o, exp.lo, exp.hi);
      end
    end
    hold = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (result_valid !== 1'b0 || stall_div !== 1'b0) begin
      errors++;
      $display("FAIL hold release: got valid=%b stall=%b want 0 0", result_valid, stall_div);
    end
  endtask

  task automatic test_reset_mid_busy();
    issue(EXE_DIV_OP, 32'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    alucontrolE = NopOp;
    rst = 1'b0;
    #1;
    checks++;
    if ({stall_div, result_valid, hi_o, lo_o} !== 66'd0) begin
      errors++;
      $display("FAIL reset mid busy: got stall=%b valid=%b hi=%h lo=%h want all 0", stall_div,
               result_valid, hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back('{lo: 32'd10, hi: 32'd0});
    issue(EXE_DIVU_OP, 32'd50, 32'd5, 1'b0);
    check_result("divu_after_reset", 33);
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_random();
    test_annul();
    test_hold();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
